// File: rtl/word_buffer_pkg.sv
// Shared constants and state encoding for the letter-packing word buffer
// and its neighbouring position-code stages.
package word_buffer_pkg;

  localparam int POS_W          = 5;
  localparam int POS_DELIM      = 0;
  localparam int POS_LETTER_MIN = 1;
  localparam int POS_LETTER_MAX = 26;
  localparam int MAXLEN_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

endpackage

// File: rtl/word_buffer_pos_is_letter.sv
// Classifies a letter position code: 1 for a..z (1..26), 0 for any delimiter.
module pos_is_letter #(
  parameter int POS_W = word_buffer_pkg::POS_W
) (
  input  logic [POS_W-1:0] pos,
  output logic             is_letter
);
  import word_buffer_pkg::*;

  assign is_letter = (pos >= POS_W'(POS_LETTER_MIN)) && (pos <= POS_W'(POS_LETTER_MAX));

endmodule

// File: rtl/word_buffer.sv
// Packs consecutive letter positions into a word and hands the finished word,
// its length and an overflow flag to the consumer over valid/ready.
module word_buffer #(
  parameter int MAXLEN = word_buffer_pkg::MAXLEN_DEFAULT,
  parameter int POS_W  = word_buffer_pkg::POS_W,
  parameter int LEN_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [POS_W-1:0]        in_pos,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MAXLEN*POS_W-1:0] out_word,
  output logic [LEN_W-1:0]        out_len,
  output logic                    out_ovf
);
  import word_buffer_pkg::*;

  state_t                  state_q, state_d;
  logic [MAXLEN*POS_W-1:0] word_q, word_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    ovf_q, ovf_d;
  logic                    in_letter;
  logic                    in_fire;

  pos_is_letter #(.POS_W(POS_W)) u_is_letter (
    .pos       (in_pos),
    .is_letter (in_letter)
  );

  assign in_ready  = (state_q != ST_EMIT);
  assign out_valid = (state_q == ST_EMIT);
  assign in_fire   = in_valid && in_ready;

  assign out_word  = word_q;
  assign out_len   = out_valid ? len_q : '0;
  assign out_ovf   = out_valid ? ovf_q : 1'b0;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (in_fire) begin
          if (in_letter) begin
            if (len_q < LEN_W'(MAXLEN)) begin
              for (int k = 0; k < MAXLEN; k++) begin
                if (len_q == LEN_W'(k)) word_d[k*POS_W +: POS_W] = in_pos;
              end
              len_d = len_q + LEN_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
            state_d = ST_COLLECT;
          end else if (state_q == ST_COLLECT) begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          word_d  = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the word register is plain flops, so clearing it on reset is cheap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_word_buffer.sv
// Self-checking bench for word_buffer: directed scenarios plus randomized
// traffic compared against a queue-based word model.
module tb_word_buffer;

  localparam int MAXLEN = 8;
  localparam int POS_W  = 5;
  localparam int LEN_W  = 4;
  localparam int WW     = MAXLEN * POS_W;

  typedef struct packed {
    logic [WW-1:0]    word;
    logic [LEN_W-1:0] len;
    logic             ovf;
  } wrd_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [POS_W-1:0] in_pos;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WW-1:0]    out_word;
  logic [LEN_W-1:0] out_len;
  logic             out_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  wrd_t             obs_q[$];
  wrd_t             exp_q[$];
  logic [POS_W-1:0] cur_q[$];
  logic             cur_ovf;

  logic          rdy_seen, vld_seen, acc_seen;
  logic [WW-1:0] word_seen;
  int            vld_cnt, rdy_low_cnt, idle_bad;

  word_buffer #(.MAXLEN(MAXLEN), .POS_W(POS_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_pos    (in_pos),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_len   (out_len),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: letters gathered in a queue, word formed on a delimiter.
  task automatic model_push(input logic [POS_W-1:0] p);
    wrd_t w;
    if (p >= 1 && p <= 26) begin
      if (cur_q.size() < MAXLEN) cur_q.push_back(p);
      else cur_ovf = 1'b1;
    end else if (cur_q.size() > 0) begin
      w = '0;
      for (int k = 0; k < cur_q.size(); k++) w.word = w.word | (WW'(cur_q[k]) << (POS_W * k));
      w.len = LEN_W'(cur_q.size());
      w.ovf = cur_ovf;
      exp_q.push_back(w);
      cur_q.delete();
      cur_ovf = 1'b0;
    end
  endtask

  task automatic clear_tracking();
    obs_q.delete();
    exp_q.delete();
    vld_cnt = 0;
    rdy_low_cnt = 0;
    idle_bad = 0;
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input logic v, input logic [POS_W-1:0] p, input logic ordy);
    wrd_t o;
    in_valid  = v;
    in_pos    = p;
    out_ready = ordy;
    #1;
    rdy_seen  = in_ready;
    vld_seen  = out_valid;
    word_seen = out_word;
    acc_seen  = v && in_ready;
    if (acc_seen) model_push(p);
    if (out_valid) vld_cnt++;
    if (!in_ready) rdy_low_cnt++;
    if (!out_valid && (out_len !== '0 || out_ovf !== 1'b0)) idle_bad++;
    if (out_valid && ordy) begin
      o.word = out_word;
      o.len  = out_len;
      o.ovf  = out_ovf;
      obs_q.push_back(o);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold a code valid until accepted; out_ready toggles randomly at rdy_pct percent.
  task automatic send(input logic [POS_W-1:0] p, input int rdy_pct);
    int n = 0;
    do begin
      step(1'b1, p, ($urandom_range(0, 99) < rdy_pct));
      n++;
    end while (!acc_seen && n < 50);
    if (!acc_seen) begin
      n_checks++;
      $display("FAIL send_timeout: code %0d not accepted within 50 cycles", p);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  task automatic apply_reset(input logic v, input logic [POS_W-1:0] p);
    rst_n     = 1'b0;
    in_valid  = v;
    in_pos    = p;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    cur_q.delete();
    cur_ovf = 1'b0;
    clear_tracking();
  endtask

  task automatic test_reset();
    apply_reset(1'b1, 5'd3);
    apply_reset(1'b0, 5'd0);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_word !== '0) $display("FAIL reset_out_word got %h want 0", out_word); else n_pass++;
    n_checks++; if (out_len !== '0 || out_ovf !== 1'b0) $display("FAIL reset_len_ovf got %0d/%b want 0/0", out_len, out_ovf); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_tracking();
    send(5'd3, 100); send(5'd1, 100); send(5'd20, 100); send(5'd0, 100);
    drain(3);
    n_checks++; if (obs_q.size() !== 1) $display("FAIL basic_count got %0d want 1", obs_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() < 1 || obs_q[0] !== {40'h5023, 4'd3, 1'b0})
      $display("FAIL basic_word got %p want word=5023 len=3 ovf=0", obs_q); else n_pass++;
    n_checks++; if (vld_cnt !== 1) $display("FAIL basic_valid_cycles got %0d want 1", vld_cnt); else n_pass++;
    n_checks++; if (rdy_seen !== 1'b1) $display("FAIL basic_ready_after got %b want 1", rdy_seen); else n_pass++;
  endtask

  task automatic test_overflow();
    clear_tracking();
    for (int i = 0; i < 10; i++) send(5'd1, 100);
    send(5'd0, 100);
    drain(3);
    n_checks++; if (obs_q.size() !== 1 || obs_q[0] !== {40'h0842108421, 4'd8, 1'b1})
      $display("FAIL overflow_word got %p want word=0842108421 len=8 ovf=1", obs_q); else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_tracking();
    send(5'd3, 100); send(5'd1, 100); send(5'd20, 100); send(5'd0, 100);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd5, 1'b0);
      n_checks++; if (vld_seen !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", i, vld_seen); else n_pass++;
      n_checks++; if (rdy_seen !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", i, rdy_seen); else n_pass++;
      n_checks++; if (word_seen !== 40'h5023) $display("FAIL bp_word_stable[%0d] got %h want 5023", i, word_seen); else n_pass++;
    end
    step(1'b1, 5'd5, 1'b1);
    step(1'b1, 5'd5, 1'b1);
    step(1'b1, 5'd0, 1'b1);
    drain(3);
    n_checks++; if (obs_q.size() !== 2) $display("FAIL bp_count got %0d want 2", obs_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() < 2 || obs_q[1] !== {40'h5, 4'd1, 1'b0})
      $display("FAIL bp_next_word got %p want second word=5 len=1", obs_q); else n_pass++;
  endtask

  task automatic test_delim_runs();
    logic [POS_W-1:0] seq[8] = '{5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd31, 5'd4, 5'd27};
    clear_tracking();
    foreach (seq[i]) send(seq[i], 100);
    drain(3);
    n_checks++; if (obs_q.size() !== 2) $display("FAIL delim_count got %0d want 2", obs_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() < 2 || obs_q[0] !== {40'h2, 4'd1, 1'b0} || obs_q[1] !== {40'h4, 4'd1, 1'b0})
      $display("FAIL delim_words got %p want (2,1) then (4,1)", obs_q); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_tracking();
    send(5'd3, 100); send(5'd1, 100);
    apply_reset(1'b1, 5'd9);
    send(5'd7, 100); send(5'd0, 100);
    drain(3);
    n_checks++; if (obs_q.size() !== 1 || obs_q[0] !== {40'h7, 4'd1, 1'b0})
      $display("FAIL reset_mid_word got %p want single word=7 len=1 ovf=0", obs_q); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_tracking();
    send(5'd1, 100); send(5'd2, 100); send(5'd0, 100); send(5'd3, 100); send(5'd0, 100);
    drain(3);
    n_checks++; if (obs_q.size() !== 2 || obs_q[0] !== {40'h41, 4'd2, 1'b0} || obs_q[1] !== {40'h3, 4'd1, 1'b0})
      $display("FAIL b2b_words got %p want (41,2) then (3,1)", obs_q); else n_pass++;
    n_checks++; if (rdy_low_cnt !== 2) $display("FAIL b2b_ready_low got %0d cycles want 2", rdy_low_cnt); else n_pass++;
  endtask

  task automatic test_random();
    int nw, d;
    clear_tracking();
    for (int w = 0; w < 60; w++) begin
      nw = $urandom_range(1, 11);
      for (int i = 0; i < nw; i++) send(5'($urandom_range(1, 26)), 70);
      for (int i = 0, n = $urandom_range(1, 2); i < n; i++) begin
        d = $urandom_range(26, 31);
        send((d == 26) ? 5'd0 : 5'(d), 70);
      end
    end
    drain(4);
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL rand_word[%0d] got word=%h len=%0d ovf=%b want word=%h len=%0d ovf=%b",
                 i, obs_q[i].word, obs_q[i].len, obs_q[i].ovf, exp_q[i].word, exp_q[i].len, exp_q[i].ovf);
      else n_pass++;
    end
    n_checks++; if (idle_bad !== 0) $display("FAIL rand_idle_len_ovf got %0d nonzero cycles want 0", idle_bad); else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pos    = '0;
    out_ready = 1'b0;
    cur_ovf   = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_delim_runs();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
